// File: rtl/ascon_ctrl_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ascon_ctrl_fsm
// Description : Sequencing controller for an Ascon AEAD datapath. Walks a
//               message through initialisation, associated-data blocks,
//               plaintext blocks, finalisation and tag output, and drives
//               the round index, enables and bypass-XOR selects.
//               Optional feature macro: ASCON_CYCLE_CNT_EN adds cycle_cnt_o,
//               a saturating count of busy cycles for the current message.
// Revision    : 1.0 - initial release
// ============================================================================
module ascon_ctrl_fsm #(
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 6
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic         ad_present_i,
    input  logic         block_valid_i,
    input  logic         block_last_i,
    input  logic [127:0] block_i,
    output logic         block_ready_o,
    output logic [127:0] data_o,
    output logic         input_mode_o,
    output logic [3:0]   round_o,
    output logic         enable_o,
    output logic [1:0]   bypass_xor_begin_o,
    output logic [1:0]   bypass_xor_end_o,
    output logic         cipher_valid_o,
    output logic         tag_valid_o,
`ifdef ASCON_CYCLE_CNT_EN
    output logic [15:0]  cycle_cnt_o,
`endif
    output logic         busy_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_WAIT_AD = 3'd2,
        S_AD      = 3'd3,
        S_WAIT_PT = 3'd4,
        S_PT      = 3'd5,
        S_FINAL   = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    // Round index of the first round and counter value of the last round
    localparam logic [3:0] c_base_a = 4'(12 - ROUNDS_A);
    localparam logic [3:0] c_base_b = 4'(12 - ROUNDS_B);
    localparam logic [3:0] c_end_a  = 4'(ROUNDS_A - 1);
    localparam logic [3:0] c_end_b  = 4'(ROUNDS_B - 1);

    state_t         r_state;
    state_t         w_state_next;
    logic [3:0]     r_cnt;
    logic [3:0]     w_cnt_next;
    logic           r_ad_present;
    logic           r_last;
    logic [127:0]   r_data;
    logic           w_perm;
    logic           w_hs;

    assign data_o = r_data;
    assign w_hs   = block_ready_o & block_valid_i;

    // State, round counter, latched flags and captured block
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_ad_present <= 1'b0;
            r_last       <= 1'b0;
            r_data       <= 128'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (r_state == S_IDLE && start_i) begin
                r_ad_present <= ad_present_i;
            end
            if (w_hs) begin
                r_data <= block_i;
                r_last <= block_last_i;
            end
        end
    end

    // Next state and outputs; outputs decode registered state only
    always_comb begin
        w_state_next       = r_state;
        w_perm             = 1'b0;
        block_ready_o      = 1'b0;
        input_mode_o       = 1'b0;
        round_o            = 4'd0;
        enable_o           = 1'b0;
        bypass_xor_begin_o = 2'b00;
        bypass_xor_end_o   = 2'b00;
        cipher_valid_o     = 1'b0;
        tag_valid_o        = 1'b0;
        busy_o             = (r_state != S_IDLE);

        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_next = S_INIT;
                end
            end
            S_INIT: begin
                w_perm       = 1'b1;
                enable_o     = 1'b1;
                round_o      = c_base_a + r_cnt;
                input_mode_o = (r_cnt == 4'd0);
                if (r_cnt == c_end_a) begin
                    bypass_xor_end_o = r_ad_present ? 2'b01 : 2'b11;
                    w_state_next     = r_ad_present ? S_WAIT_AD : S_WAIT_PT;
                end
            end
            S_WAIT_AD: begin
                block_ready_o = 1'b1;
                if (block_valid_i) begin
                    w_state_next = S_AD;
                end
            end
            S_AD: begin
                w_perm   = 1'b1;
                enable_o = 1'b1;
                round_o  = c_base_b + r_cnt;
                if (r_cnt == 4'd0) begin
                    bypass_xor_begin_o = 2'b01;
                end
                if (r_cnt == c_end_b) begin
                    bypass_xor_end_o = r_last ? 2'b10 : 2'b00;
                    w_state_next     = r_last ? S_WAIT_PT : S_WAIT_AD;
                end
            end
            S_WAIT_PT: begin
                block_ready_o = 1'b1;
                if (block_valid_i) begin
                    w_state_next = block_last_i ? S_FINAL : S_PT;
                end
            end
            S_PT: begin
                w_perm         = 1'b1;
                enable_o       = 1'b1;
                round_o        = c_base_b + r_cnt;
                cipher_valid_o = (r_cnt == 4'd0);
                if (r_cnt == c_end_b) begin
                    w_state_next = S_WAIT_PT;
                end
            end
            S_FINAL: begin
                w_perm   = 1'b1;
                enable_o = 1'b1;
                round_o  = c_base_a + r_cnt;
                if (r_cnt == 4'd0) begin
                    bypass_xor_begin_o = 2'b11;
                    cipher_valid_o     = 1'b1;
                end
                if (r_cnt == c_end_a) begin
                    bypass_xor_end_o = 2'b01;
                    w_state_next     = S_DONE;
                end
            end
            S_DONE: begin
                tag_valid_o  = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Counter restarts on every state entry and advances only in permutations
        if (w_state_next != r_state) begin
            w_cnt_next = 4'd0;
        end else if (w_perm) begin
            w_cnt_next = r_cnt + 4'd1;
        end else begin
            w_cnt_next = r_cnt;
        end
    end

`ifdef ASCON_CYCLE_CNT_EN
    logic [15:0] r_cycle_cnt;

    assign cycle_cnt_o = r_cycle_cnt;

    // Busy-cycle counter: cleared on accepted start, saturates, holds in IDLE
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_cycle_cnt <= 16'd0;
        end else if (r_state == S_IDLE && start_i) begin
            r_cycle_cnt <= 16'd0;
        end else if (busy_o && r_cycle_cnt != 16'hFFFF) begin
            r_cycle_cnt <= r_cycle_cnt + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ascon_ctrl_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ascon_ctrl_fsm
// Description : Self-checking bench for ascon_ctrl_fsm. Two instances
//               (12/6 and 8/4 rounds). Each message is first expanded into
//               a per-cycle list of expected outputs from the protocol
//               phases, then driven with random gaps and ignored noise.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ascon_ctrl_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_s [2];
    logic         start_s [2];
    logic         adp_s   [2];
    logic         valid_s [2];
    logic         last_s  [2];
    logic [127:0] blk_s   [2];
    logic         ready_s [2];
    logic [127:0] data_s  [2];
    logic         im_s    [2];
    logic [3:0]   rnd_s   [2];
    logic         en_s    [2];
    logic [1:0]   xb_s    [2];
    logic [1:0]   xe_s    [2];
    logic         cv_s    [2];
    logic         tv_s    [2];
    logic         busy_s  [2];
`ifdef ASCON_CYCLE_CNT_EN
    logic [15:0]  cyc_s   [2];
`endif

    ascon_ctrl_fsm #(.ROUNDS_A(12), .ROUNDS_B(6)) u_dut0 (
        .clock_i(clk), .reset_i(reset_s[0]), .start_i(start_s[0]),
        .ad_present_i(adp_s[0]), .block_valid_i(valid_s[0]),
        .block_last_i(last_s[0]), .block_i(blk_s[0]),
        .block_ready_o(ready_s[0]), .data_o(data_s[0]),
        .input_mode_o(im_s[0]), .round_o(rnd_s[0]), .enable_o(en_s[0]),
        .bypass_xor_begin_o(xb_s[0]), .bypass_xor_end_o(xe_s[0]),
        .cipher_valid_o(cv_s[0]), .tag_valid_o(tv_s[0]),
`ifdef ASCON_CYCLE_CNT_EN
        .cycle_cnt_o(cyc_s[0]),
`endif
        .busy_o(busy_s[0])
    );

    ascon_ctrl_fsm #(.ROUNDS_A(8), .ROUNDS_B(4)) u_dut1 (
        .clock_i(clk), .reset_i(reset_s[1]), .start_i(start_s[1]),
        .ad_present_i(adp_s[1]), .block_valid_i(valid_s[1]),
        .block_last_i(last_s[1]), .block_i(blk_s[1]),
        .block_ready_o(ready_s[1]), .data_o(data_s[1]),
        .input_mode_o(im_s[1]), .round_o(rnd_s[1]), .enable_o(en_s[1]),
        .bypass_xor_begin_o(xb_s[1]), .bypass_xor_end_o(xe_s[1]),
        .cipher_valid_o(cv_s[1]), .tag_valid_o(tv_s[1]),
`ifdef ASCON_CYCLE_CNT_EN
        .cycle_cnt_o(cyc_s[1]),
`endif
        .busy_o(busy_s[1])
    );

    // One expected cycle: stimulus hints plus the outputs the DUT must show
    typedef struct packed {
        logic         st;
        logic         hs;
        logic         last;
        logic [127:0] blk;
        logic [13:0]  outv;
        logic [127:0] data;
    } cyc_t;

    cyc_t         plan [$];
    logic [127:0] build_data;
    logic [127:0] model_data [2];
    int           n_cmp = 0;
    int           n_bad = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Output vector layout: busy ready enable round[3:0] input_mode begin[1:0] end[1:0] cipher tag
    function automatic logic [13:0] pack_out(logic b, logic r, logic e, logic [3:0] rn,
                                             logic im, logic [1:0] xb, logic [1:0] xe,
                                             logic cv, logic tv);
        return {b, r, e, rn, im, xb, xe, cv, tv};
    endfunction

    function automatic logic [13:0] obs(int s);
        return {busy_s[s], ready_s[s], en_s[s], rnd_s[s], im_s[s], xb_s[s], xe_s[s], cv_s[s], tv_s[s]};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic void add(logic st, logic hs, logic lst, logic [127:0] b, logic [13:0] o);
        cyc_t c;
        c.st   = st;
        c.hs   = hs;
        c.last = lst;
        c.blk  = b;
        c.outv = o;
        c.data = build_data;
        plan.push_back(c);
    endfunction

    // A permutation of r rounds ending at round 11
    function automatic void add_perm(int r, logic im_first, logic [1:0] b_first,
                                     logic [1:0] e_last, logic cv_first);
        for (int k = 0; k < r; k++) begin
            add(1'b0, 1'b0, 1'b0, 128'd0,
                pack_out(1'b1, 1'b0, 1'b1, 4'(12 - r + k), im_first && (k == 0),
                         (k == 0) ? b_first : 2'b00, (k == r - 1) ? e_last : 2'b00,
                         cv_first && (k == 0), 1'b0));
        end
    endfunction

    // Waiting for a block: gap idle cycles with ready high, then the handshake
    function automatic void add_wait(int gap, logic [127:0] b, logic lst);
        for (int g = 0; g < gap; g++) begin
            add(1'b0, 1'b0, 1'b0, 128'd0, pack_out(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0));
        end
        add(1'b0, 1'b1, lst, b, pack_out(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0));
        build_data = b;
    endfunction

    function automatic void build(int s, logic ad, int n_ad, int n_pt, int gap_max);
        int ra;
        int rb;
        ra = (s == 1) ? 8 : 12;
        rb = (s == 1) ? 4 : 6;
        plan.delete();
        build_data = model_data[s];
        add(1'b1, 1'b0, 1'b0, 128'd0, 14'd0);
        add_perm(ra, 1'b1, 2'b00, ad ? 2'b01 : 2'b11, 1'b0);
        if (ad) begin
            for (int i = 0; i < n_ad; i++) begin
                add_wait($urandom_range(gap_max, 0), rnd128(), i == n_ad - 1);
                add_perm(rb, 1'b0, 2'b01, (i == n_ad - 1) ? 2'b10 : 2'b00, 1'b0);
            end
        end
        for (int i = 0; i < n_pt - 1; i++) begin
            add_wait($urandom_range(gap_max, 0), rnd128(), 1'b0);
            add_perm(rb, 1'b0, 2'b00, 2'b00, 1'b1);
        end
        add_wait($urandom_range(gap_max, 0), rnd128(), 1'b1);
        add_perm(ra, 1'b0, 2'b11, 2'b01, 1'b1);
        add(1'b0, 1'b0, 1'b0, 128'd0, pack_out(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1));
        add(1'b0, 1'b0, 1'b0, 128'd0, 14'd0);
    endfunction

    // Run one message on instance s; reset_at >= 0 asserts reset at that plan cycle
    task automatic run(input int s, input logic ad, input int n_ad, input int n_pt,
                       input int gap_max, input logic hold, input int reset_at);
        int  nbusy;
        bit  stop;
        nbusy = 0;
        stop  = 1'b0;
        build(s, ad, n_ad, n_pt, gap_max);
        for (int i = 0; i < plan.size() && !stop; i++) begin
            @(negedge clk);
            check($sformatf("u%0d cyc%0d outputs", s, i), 128'(obs(s)), 128'(plan[i].outv));
            check($sformatf("u%0d cyc%0d data_o", s, i), data_s[s], plan[i].data);
            if (plan[i].outv[13]) nbusy++;
`ifdef ASCON_CYCLE_CNT_EN
            if (i == plan.size() - 1) begin
                check($sformatf("u%0d cycle_cnt", s), 128'(cyc_s[s]), 128'(nbusy));
            end
`endif
            start_s[s] = plan[i].st | (plan[i].outv[13] & (hold | ($urandom_range(3, 0) == 0)));
            adp_s[s]   = ad;
            valid_s[s] = plan[i].hs | (~plan[i].outv[12] & (hold | 1'($urandom_range(1, 0))));
            last_s[s]  = plan[i].hs ? plan[i].last : 1'($urandom_range(1, 0));
            blk_s[s]   = plan[i].hs ? plan[i].blk : rnd128();
            if (i == reset_at) begin
                reset_s[s] = 1'b1;
                start_s[s] = 1'b1;
                valid_s[s] = 1'b1;
                @(negedge clk);
                check($sformatf("u%0d post-reset outputs", s), 128'(obs(s)), 128'd0);
                check($sformatf("u%0d post-reset data_o", s), data_s[s], 128'd0);
`ifdef ASCON_CYCLE_CNT_EN
                check($sformatf("u%0d post-reset cycle_cnt", s), 128'(cyc_s[s]), 128'd0);
`endif
                reset_s[s] = 1'b0;
                start_s[s] = 1'b0;
                valid_s[s] = 1'b0;
                build_data = 128'd0;
                stop = 1'b1;
            end
        end
        start_s[s]    = 1'b0;
        valid_s[s]    = 1'b0;
        model_data[s] = build_data;
    endtask

    // Directed scenarios followed by randomized messages on both instances
    initial begin
        for (int s = 0; s < 2; s++) begin
            reset_s[s] = 1'b1;
            start_s[s] = 1'b0;
            adp_s[s]   = 1'b0;
            valid_s[s] = 1'b0;
            last_s[s]  = 1'b0;
            blk_s[s]   = 128'd0;
            model_data[s] = 128'd0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check($sformatf("u%0d reset outputs", s), 128'(obs(s)), 128'd0);
            check($sformatf("u%0d reset data_o", s), data_s[s], 128'd0);
            reset_s[s] = 1'b0;
        end

        run(0, 1'b1, 1, 1, 0, 1'b0, -1);
        run(0, 1'b0, 0, 1, 0, 1'b0, -1);
        run(0, 1'b0, 0, 3, 0, 1'b1, -1);
        run(0, 1'b1, 2, 1, 0, 1'b1, -1);
        run(0, 1'b1, 1, 1, 0, 1'b0, 6);
        run(0, 1'b0, 0, 2, 2, 1'b0, -1);
        run(1, 1'b1, 1, 1, 0, 1'b0, -1);
        run(1, 1'b0, 0, 2, 1, 1'b1, -1);

        for (int t = 0; t < 20; t++) begin
            run($urandom_range(1, 0), 1'($urandom_range(1, 0)), $urandom_range(3, 1),
                $urandom_range(3, 1), 3, 1'b0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ascon_ctrl_fsm.md
ASCON_CTRL_FSM -- requirements
Module: ascon_ctrl_fsm

Interface
REQ-001 The block SHALL have parameter ROUNDS_A, default 12: round count of initialisation and finalisation permutations (1..12).
REQ-002 The block SHALL have parameter ROUNDS_B, default 6: round count of per-block permutations (1..12).
REQ-003 The block SHALL have ports:
- clock_i  in  1  single clock, rising edge.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle request to begin a message.
- ad_present_i  in  1  sampled with start_i; 1 = at least one associated-data (AD) block follows.
- block_valid_i  in  1  upstream block offered.
- block_last_i  in  1  offered block is last of its phase (AD or plaintext).
- block_i  in  128  offered block data.
- block_ready_o  out  1  block accepted when valid and ready are both 1.
- data_o  out  128  registered block, drives datapath data_i.
- input_mode_o  out  1  1 = datapath selects external state.
- round_o  out  4  round index to datapath.
- enable_o  out  1  datapath state-register enable.
- bypass_xor_begin_o  out  2  00 none, 01 data into rate, 11 data into rate plus key into capacity.
- bypass_xor_end_o  out  2  00 none, 01 key into capacity, 10 domain-separation bit, 11 key plus domain-separation bit.
- cipher_valid_o  out  1  ciphertext block valid on datapath this cycle.
- tag_valid_o  out  1  tag valid on datapath output.
- busy_o  out  1  message in progress.

Function
REQ-004 States SHALL be IDLE, INIT, WAIT_AD, AD, WAIT_PT, PT, FINAL, DONE.
REQ-005 In IDLE, start_i=1 SHALL latch ad_present_i and move to INIT; busy_o SHALL be 1 in every state except IDLE.
REQ-006 INIT SHALL last ROUNDS_A cycles, with enable_o=1 and round_o = 12-ROUNDS_A+k on cycle k (k from 0).
- first cycle: input_mode_o=1.
- last cycle: bypass_xor_end_o=01 if the latched ad_present is 1, else 11.
- next state: WAIT_AD if ad_present, else WAIT_PT.
REQ-007 In WAIT_AD and WAIT_PT, block_ready_o SHALL be 1 and enable_o SHALL be 0; on handshake, block_i SHALL be captured into data_o and block_last_i latched.
- WAIT_AD goes to AD.
- WAIT_PT goes to PT if not last, else FINAL.
REQ-008 block_ready_o SHALL be 0 in all other states, and block_valid_i SHALL be ignored there.
REQ-009 AD SHALL last ROUNDS_B cycles, with round_o = 12-ROUNDS_B+k.
- first cycle: bypass_xor_begin_o=01.
- last cycle: bypass_xor_end_o=10 if the latched last is 1.
- next state: WAIT_PT if last, else WAIT_AD.
REQ-010 PT SHALL have the AD timing, with cipher_valid_o=1 on its first cycle, bypass_xor_end_o=00, and next state WAIT_PT.
REQ-011 FINAL SHALL last ROUNDS_A cycles, with round_o = 12-ROUNDS_A+k.
- first cycle: bypass_xor_begin_o=11 and cipher_valid_o=1.
- last cycle: bypass_xor_end_o=01.
- next state: DONE.
REQ-012 DONE SHALL assert tag_valid_o for exactly one cycle, then return to IDLE.
REQ-013 input_mode_o, bypass outputs, cipher_valid_o and tag_valid_o SHALL be 0 except where stated above.
REQ-014 round_o SHALL hold 0 outside INIT, AD, PT and FINAL.
REQ-015 All outputs SHALL be registered or decoded from registered state only; there SHALL be no combinational path from inputs to outputs except block_ready_o, which depends on state only.
REQ-016 start_i SHALL be ignored outside IDLE.
REQ-017 The round counter SHALL be 4 bits and reset to 0 on every state entry.

Reset
REQ-018 reset_i=1 at a rising edge SHALL force IDLE, including mid-permutation, with no further enable_o pulses.
REQ-019 Reset SHALL clear data_o, the latched flags and the counter, and drive all outputs to 0.
REQ-020 reset_i SHALL take priority over start_i and the block handshake in the same cycle.

Configuration
REQ-021 With ASCON_CYCLE_CNT_EN defined, the block SHALL add output cycle_cnt_o (16 bits).
- cleared when start_i is accepted;
- incremented on every cycle with busy_o=1, saturating at 16'hFFFF;
- held in IDLE and cleared by reset.
REQ-022 Without ASCON_CYCLE_CNT_EN, the port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-023 The bench SHALL cover at least:
- Start with ad_present=1, then one AD (last) and one PT (last) block, defaults: INIT rounds 0..11, end=01 at round 11; AD rounds 6..11, end=10 at 11; FINAL begin=11, rounds 0..11; tag_valid_o one cycle later.
- ad_present=0, one PT last block: INIT last-cycle end=11; FINAL follows directly; with no data in flight, total busy 12+1(wait)+12+1 cycles, so cycle_cnt_o=26.
- Three PT blocks with handshake valid held high: ready=1 only in WAIT_PT; cipher_valid_o pulses three times; the first two PT passes use rounds 6..11.
- reset_i asserted at INIT round 5: next cycle IDLE, enable_o=0, busy_o=0, round_o=0.
- start_i pulsed during PT and block_valid_i during AD rounds: both ignored, no state change.
- ROUNDS_A=8, ROUNDS_B=4: INIT rounds 4..11; AD rounds 8..11.
